// File: rtl/bus_write_router.sv
// Routes posted writes through a DEPTH-entry FIFO to one of six targets via a one-hot strobe.
// Latency: a write accepted into an empty FIFO drives its strobe the very next cycle.
// Backpressure: WrAccept drops when the FIFO is full; a stalled head target blocks all later entries.
module bus_write_router #(
    parameter int DEPTH = 4,
    parameter int DW    = 256
) (
    input  logic          Clk,
    input  logic          nReset,
    input  logic          nWrite,
    input  logic [15:0]   address,
    input  logic [DW-1:0] DataIn,
    output logic          WrAccept,
    output logic [5:0]    WrEn,
    output logic [11:0]   WrAddr,
    output logic [DW-1:0] WrData,
    input  logic [5:0]    TgtReady,
    output logic          Busy,
    output logic          ErrUnmapped
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    typedef struct packed {
        logic [2:0]    code;
        logic [11:0]   off;
        logic [DW-1:0] dat;
    } ent_t;

    ent_t          mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] prev_ptr;
    logic [AW:0]   count;
    state_t        state;
    state_t        state_nxt;
    logic          accept;
    logic          mapped;
    logic          push;
    logic          pop;
    ent_t          head;
    ent_t          shown;

    // Acceptance depends only on the registered count, never on a same-cycle pop.
    assign WrAccept = (count < (AW+1)'(DEPTH));
    assign Busy     = (count != '0);
    assign accept   = !nWrite && WrAccept;
    assign mapped   = (address[15:12] <= 4'd5);
    assign push     = accept && mapped;
    assign head     = mem[rd_ptr];
    assign pop      = (state == ISSUE) && TgtReady[head.code];

    // When idle, the slot just behind the read pointer still holds the last
    // completed entry; it is only overwritten after DEPTH-1 further pushes,
    // by which point the FIFO is no longer idle.
    assign prev_ptr = rd_ptr - AW'(1);
    assign shown    = (state == ISSUE) ? head : mem[prev_ptr];
    assign WrAddr   = shown.off;
    assign WrData   = shown.dat;

    // FIFO storage and pointers; memory is cleared so idle outputs read zero after reset.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{code: address[14:12], off: address[11:0], dat: DataIn};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Occupancy count; a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Dropped write to an unmapped code is flagged for exactly the following cycle.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) ErrUnmapped <= 1'b0;
        else         ErrUnmapped <= accept && !mapped;
    end

    // State register.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next state and target strobe.
    always_comb begin
        state_nxt = state;
        WrEn      = '0;
        case (state)
            IDLE: begin
                if (push) state_nxt = ISSUE;
            end
            ISSUE: begin
                WrEn[head.code] = 1'b1;
                if (pop && !push && count == (AW+1)'(1)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_write_router.sv
// Randomized and directed bench for bus_write_router against a queue-based reference model.
// The model tracks the posted-write FIFO contents and derives every output from them.
// Directed phases pin single write, fill, unmapped, stall ordering, wrap and mid-drain reset.
module tb_bus_write_router;

    localparam int DEPTH = 4;
    localparam int DW    = 256;

    logic          Clk = 1'b0;
    logic          nReset = 1'b0;
    logic          nWrite = 1'b1;
    logic [15:0]   address = '0;
    logic [DW-1:0] DataIn = '0;
    logic          WrAccept;
    logic [5:0]    WrEn;
    logic [11:0]   WrAddr;
    logic [DW-1:0] WrData;
    logic [5:0]    TgtReady = '0;
    logic          Busy;
    logic          ErrUnmapped;

    int tests = 0;
    int fails = 0;

    bus_write_router #(.DEPTH(DEPTH), .DW(DW)) dut (
        .Clk(Clk), .nReset(nReset), .nWrite(nWrite), .address(address),
        .DataIn(DataIn), .WrAccept(WrAccept), .WrEn(WrEn), .WrAddr(WrAddr),
        .WrData(WrData), .TgtReady(TgtReady), .Busy(Busy), .ErrUnmapped(ErrUnmapped)
    );

    always #5 Clk = ~Clk;

    // ---------------- reference model ----------------
    typedef struct {
        int            code;
        logic [11:0]   off;
        logic [DW-1:0] dat;
    } ment_t;

    ment_t         q[$];
    ment_t         m_ent;
    ment_t         m_done;
    logic [11:0]   last_off = '0;
    logic [DW-1:0] last_dat = '0;
    logic          m_err = 1'b0;
    logic          m_acc;
    logic          m_pop;

    always @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            q.delete();
            m_err    = 1'b0;
            last_off = '0;
            last_dat = '0;
        end else begin
            m_acc = !nWrite && (q.size() < DEPTH);
            m_pop = (q.size() > 0) && TgtReady[q[0].code];
            m_err = m_acc && (address[15:12] > 4'd5);
            if (m_pop) begin
                m_done   = q.pop_front();
                last_off = m_done.off;
                last_dat = m_done.dat;
            end
            if (m_acc && address[15:12] <= 4'd5) begin
                m_ent.code = int'(address[15:12]);
                m_ent.off  = address[11:0];
                m_ent.dat  = DataIn;
                q.push_back(m_ent);
            end
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge Clk) begin
        logic [5:0] exp_en;
        exp_en = '0;
        if (q.size() > 0) exp_en[q[0].code] = 1'b1;
        check("m_wraccept", DW'(WrAccept), DW'(q.size() < DEPTH));
        check("m_busy",     DW'(Busy),     DW'(q.size() != 0));
        check("m_wren",     DW'(WrEn),     DW'(exp_en));
        check("m_err",      DW'(ErrUnmapped), DW'(m_err));
        check("m_wraddr",   DW'(WrAddr),   DW'((q.size() > 0) ? q[0].off : last_off));
        check("m_wrdata",   WrData,        (q.size() > 0) ? q[0].dat : last_dat);
    end

    // ---------------- stimulus ----------------
    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic cyc();
        @(posedge Clk);
        #2;
    endtask

    task automatic wr(input logic [15:0] a, input logic [DW-1:0] d);
        nWrite  = 1'b0;
        address = a;
        DataIn  = d;
    endtask

    logic [DW-1:0] d1;
    logic [DW-1:0] dv [5];

    initial begin
        // Reset state.
        #3;
        check("rst_wraccept", DW'(WrAccept), DW'(1));
        check("rst_wren",     DW'(WrEn), '0);
        check("rst_wraddr",   DW'(WrAddr), '0);
        check("rst_wrdata",   WrData, '0);
        check("rst_busy",     DW'(Busy), '0);
        check("rst_err",      DW'(ErrUnmapped), '0);
        cyc();
        cyc();
        nReset = 1'b1;
        cyc();

        // Single write to MatrixAlu with all targets ready.
        TgtReady = 6'h3F;
        d1 = rnd_data();
        wr(16'h3010, d1);
        cyc();
        nWrite = 1'b1;
        check("single_wren",   DW'(WrEn), DW'(6'b001000));
        check("single_wraddr", DW'(WrAddr), DW'(12'h010));
        check("single_wrdata", WrData, d1);
        check("single_busy",   DW'(Busy), DW'(1));
        cyc();
        check("single_done_busy", DW'(Busy), '0);
        check("single_hold_addr", DW'(WrAddr), DW'(12'h010));

        // Fill with targets stalled: the fifth request is refused.
        TgtReady = '0;
        for (int i = 0; i < 5; i++) begin
            dv[i] = rnd_data();
            check("fill_accept", DW'(WrAccept), DW'(i < 4));
            wr(16'(i), dv[i]);
            cyc();
        end
        nWrite = 1'b1;
        check("fill_full", DW'(WrAccept), '0);
        TgtReady = 6'b000001;
        for (int i = 0; i < 4; i++) begin
            check("drain_data", WrData, dv[i]);
            check("drain_wren", DW'(WrEn), DW'(6'b000001));
            cyc();
        end
        check("drain_empty", DW'(Busy), '0);

        // Unmapped code: error pulse, nothing queued.
        TgtReady = 6'h3F;
        wr(16'h7000, rnd_data());
        cyc();
        nWrite = 1'b1;
        check("unmapped_err",  DW'(ErrUnmapped), DW'(1));
        check("unmapped_wren", DW'(WrEn), '0);
        check("unmapped_busy", DW'(Busy), '0);
        cyc();
        check("unmapped_pulse_end", DW'(ErrUnmapped), '0);

        // Ordering behind a stalled head.
        TgtReady = 6'h2F;
        wr(16'h4001, rnd_data());
        cyc();
        check("stall_wren0", DW'(WrEn), DW'(6'b010000));
        wr(16'h1002, rnd_data());
        cyc();
        check("stall_wren1", DW'(WrEn), DW'(6'b010000));
        wr(16'h5003, rnd_data());
        cyc();
        nWrite = 1'b1;
        check("stall_wren2", DW'(WrEn), DW'(6'b010000));
        TgtReady = 6'h3F;
        cyc();
        check("order_reg",  DW'(WrEn), DW'(6'b000010));
        cyc();
        check("order_exec", DW'(WrEn), DW'(6'b100000));
        cyc();
        check("order_idle", DW'(WrEn), '0);

        // Continuous writes across pointer wrap, one per cycle.
        for (int i = 0; i < 10; i++) begin
            check("wrap_accept", DW'(WrAccept), DW'(1));
            wr({4'($urandom_range(0, 5)), 12'($urandom)}, rnd_data());
            cyc();
        end
        nWrite = 1'b1;
        cyc();
        check("wrap_drained", DW'(Busy), '0);

        // Reset mid-drain with three entries queued.
        TgtReady = '0;
        for (int i = 0; i < 3; i++) begin
            wr(16'h2000 + 16'(i), rnd_data());
            cyc();
        end
        nWrite = 1'b1;
        check("pre_reset_busy", DW'(Busy), DW'(1));
        nReset = 1'b0;
        #1;
        check("reset_wren",     DW'(WrEn), '0);
        check("reset_busy",     DW'(Busy), '0);
        check("reset_wraccept", DW'(WrAccept), DW'(1));
        cyc();
        nReset = 1'b1;
        TgtReady = '0;
        wr(16'h0123, rnd_data());
        cyc();
        nWrite = 1'b1;
        check("post_reset_accept", DW'(Busy), DW'(1));
        TgtReady = 6'h3F;
        cyc();

        // Randomized traffic, including unmapped codes and random target stalls.
        for (int i = 0; i < 600; i++) begin
            nWrite   = ($urandom_range(0, 3) == 0);
            address  = {4'(($urandom_range(0, 7) < 6) ? $urandom_range(0, 5) : $urandom_range(6, 15)),
                        12'($urandom)};
            DataIn   = rnd_data();
            TgtReady = 6'($urandom);
            cyc();
        end
        nWrite   = 1'b1;
        TgtReady = 6'h3F;
        for (int i = 0; i < DEPTH + 2; i++) cyc();
        check("final_idle", DW'(Busy), '0);

        @(negedge Clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
